// File: rtl/codec_spi_init.sv
// Power-up sequencer for the TLV320AIC3254: pulses the codec reset, then writes a fixed
// register table over SPI (mode 0, MSB first). Optional readback via CODEC_READBACK_EN.
module codec_spi_init #(
    parameter int DIV         = 14,
    parameter int RST_CYCLES  = 56,
    parameter int WAKE_CYCLES = 56000,
    parameter int GAP         = 28
) (
    input  logic clock,
    input  logic reset,
    output logic codecRstN,
    output logic csN,
    output logic sck,
    output logic mosi,
    input  logic miso,
    output logic busy,
    output logic done,
    output logic error
);

    localparam int M1   = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
    localparam int M2   = (DIV > GAP) ? DIV : GAP;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_RST, S_WAKE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE
    } state_t;

    // Register table as {addr[6:0], data[7:0]}.
    function automatic logic [14:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = {7'h00, 8'h00};
            3'd1:    table_entry = {7'h01, 8'h01};
            3'd2:    table_entry = {7'h1B, 8'h00};
            3'd3:    table_entry = {7'h3C, 8'h01};
            3'd4:    table_entry = {7'h3F, 8'hD4};
            3'd5:    table_entry = {7'h40, 8'h00};
            3'd6:    table_entry = {7'h00, 8'h01};
            3'd7:    table_entry = {7'h0C, 8'h08};
            default: table_entry = {7'h00, 8'h00};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    bit_q, bit_d;
    logic          half_q, half_d;
    logic [15:0]   frame_q, frame_d;
    logic          rstn_q, rstn_d;
    logic          csn_q, csn_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [14:0]   entry_s;

    assign entry_s = table_entry(idx_q);

`ifdef CODEC_READBACK_EN
    logic       rd_q, rd_d;
    logic [7:0] rx_q, rx_d;
`else
    logic       unused_miso_s;
    assign unused_miso_s = miso;
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            bit_q   <= 4'd0;
            half_q  <= 1'b0;
            frame_q <= 16'h0000;
            rstn_q  <= 1'b0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef CODEC_READBACK_EN
            rd_q    <= 1'b0;
            rx_q    <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            frame_q <= frame_d;
            rstn_q  <= rstn_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef CODEC_READBACK_EN
            rd_q    <= rd_d;
            rx_q    <= rx_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        half_d  = half_q;
        frame_d = frame_q;
        rstn_d  = rstn_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef CODEC_READBACK_EN
        rd_d    = rd_q;
        rx_d    = rx_q;
`else
        error_d = 1'b0;
`endif
        case (state_q)
            S_RST: begin
                rstn_d = 1'b0;
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    rstn_d  = 1'b1;
                    state_d = S_WAKE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD: begin
`ifdef CODEC_READBACK_EN
                if (rd_q) begin
                    frame_d = {entry_s[14:8], 1'b1, 8'h00};
                end else begin
                    frame_d = {entry_s[14:8], 1'b0, entry_s[7:0]};
                end
`else
                frame_d = {entry_s[14:8], 1'b0, entry_s[7:0]};
`endif
                cnt_d   = '0;
                csn_d   = 1'b0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    mosi_d  = frame_q[15];
                    bit_d   = 4'd15;
                    half_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!half_q) begin
                    // Rising edge: codec latches mosi, we latch the readback bit.
                    cnt_d  = '0;
                    sck_d  = 1'b1;
                    half_d = 1'b1;
`ifdef CODEC_READBACK_EN
                    if (bit_q < 4'd8) begin
                        rx_d = {rx_q[6:0], miso};
                    end else begin
                        rx_d = rx_q;
                    end
`endif
                end else begin
                    cnt_d  = '0;
                    sck_d  = 1'b0;
                    half_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q - 4'd1;
                        frame_d = {frame_q[14:0], 1'b0};
                        mosi_d  = frame_q[14];
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
`ifdef CODEC_READBACK_EN
                    if (rd_q) begin
                        error_d = error_q | (rx_q != entry_s[7:0]);
                    end else begin
                        error_d = error_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
`ifdef CODEC_READBACK_EN
                    // Every write except the soft reset is followed by a read of the same register.
                    if (!rd_q && (entry_s[14:8] != 7'h01)) begin
                        rd_d    = 1'b1;
                        state_d = S_LOAD;
                    end else if (idx_q == 3'd7) begin
                        rd_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd_d    = 1'b0;
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
`else
                    if (idx_q == 3'd7) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
`endif
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign codecRstN = rstn_q;
    assign csN       = csn_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_codec_spi_init.sv
// Bench for codec_spi_init: SPI frame capture, codec readback model, timing and abort checks.
module tb_codec_spi_init;
    localparam int DIV        = 2;
    localparam int RSTC       = 4;
    localparam int WAKEC      = 10;
    localparam int GAPC       = 3;
    localparam int FRAME_CLKS = DIV + 32 * DIV + DIV + GAPC + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic miso  = 1'b0;
    logic codecRstN, csN, sck, mosi, busy, done, error;

    always #5 clock = ~clock;

    codec_spi_init #(
        .DIV(DIV), .RST_CYCLES(RSTC), .WAKE_CYCLES(WAKEC), .GAP(GAPC)
    ) dut (
        .clock(clock), .reset(reset), .codecRstN(codecRstN), .csN(csN), .sck(sck),
        .mosi(mosi), .miso(miso), .busy(busy), .done(done), .error(error)
    );

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;

    logic [6:0] t_addr [8] = '{7'h00, 7'h01, 7'h1B, 7'h3C, 7'h3F, 7'h40, 7'h00, 7'h0C};
    logic [7:0] t_data [8] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hD4, 8'h00, 8'h01, 8'h08};

    logic        prev_csn = 1'b1, prev_sck = 1'b0, prev_rstn = 1'b0;
    int          bits_in = 0, hi_clks = 0, pulses = 0;
    logic [15:0] sh = 16'h0000;
    logic [7:0]  hdr = 8'h00;
    logic [7:0]  resp;
    logic [7:0]  mem [128];
    logic        corrupt = 1'b0;
    int unsigned rise_cyc = 0;
    logic [15:0] cap_q [$];
    int          hi_q [$];
    int          pul_q [$];
    int unsigned fall_q [$];
    logic        err_q [$];
    logic [15:0] exp_q [$];
    logic        exp_err [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Codec side: capture frames on SCK rise, answer reads from remembered writes.
    always @(negedge clock) begin
        if (codecRstN && !prev_rstn) rise_cyc = cyc;
        if (!csN && prev_csn) begin
            fall_q.push_back(cyc);
            bits_in = 0; hi_clks = 0; pulses = 0;
        end
        if (!csN && sck) hi_clks++;
        if (!csN && sck && !prev_sck) begin
            sh = {sh[14:0], mosi};
            bits_in++;
            pulses++;
            if (bits_in == 8) hdr = sh[7:0];
        end
        if (csN && !prev_csn && bits_in == 16) begin
            cap_q.push_back(sh);
            hi_q.push_back(hi_clks);
            pul_q.push_back(pulses);
            err_q.push_back(error);
            if (!sh[8]) mem[sh[15:9]] = sh[7:0];
        end
`ifdef CODEC_READBACK_EN
        if (!csN && bits_in >= 8 && bits_in < 16 && hdr[0]) begin
            resp = (corrupt && hdr[7:1] == 7'h3F) ? 8'hFF : mem[hdr[7:1]];
            miso = resp[15 - bits_in];
        end else begin
            miso = 1'b0;
        end
`else
        miso = 1'($urandom);
`endif
        prev_csn  = csN;
        prev_sck  = sck;
        prev_rstn = codecRstN;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame list and sticky error trace, derived from the table rules.
    task automatic build_expected(input logic crp);
        logic e;
        exp_q.delete();
        exp_err.delete();
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({t_addr[i], 1'b0, t_data[i]});
            exp_err.push_back(e);
`ifdef CODEC_READBACK_EN
            if (t_addr[i] != 7'h01) begin
                exp_q.push_back({t_addr[i], 1'b1, 8'h00});
                if (crp && t_addr[i] == 7'h3F) e = 1'b1;
                exp_err.push_back(e);
            end
`endif
        end
    endtask

    task automatic clear_capture();
        cap_q.delete(); hi_q.delete(); pul_q.delete(); fall_q.delete(); err_q.delete();
    endtask

    task automatic do_run(input logic crp);
        int unsigned c0;
        int n;
        corrupt = crp;
        build_expected(crp);
        clear_capture();
        @(negedge clock);
        reset = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 6000 && !done; k++) @(negedge clock);
        check("done_at_end", done, 1);
        check("busy_at_end", busy, 0);
        check("error_at_end", error, exp_err[exp_err.size() - 1]);
        check("csn_idle", csN, 1);
        check("rstn_low_clocks", rise_cyc - c0, RSTC);
        check("frame_count", cap_q.size(), exp_q.size());
        if (fall_q.size() > 0) check("first_cs_fall", fall_q[0] - rise_cyc, WAKEC + 1);
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("frame%0d", i), cap_q[i], exp_q[i]);
            check($sformatf("sck_high%0d", i), hi_q[i], 16 * DIV);
            check($sformatf("pulses%0d", i), pul_q[i], 16);
            check($sformatf("err_after%0d", i), err_q[i], exp_err[i]);
        end
        for (int i = 1; i < fall_q.size(); i++)
            check($sformatf("frame_len%0d", i - 1), fall_q[i] - fall_q[i - 1], FRAME_CLKS);
        repeat (20) @(negedge clock);
        check("done_sticky", done, 1);
        check("busy_stays_low", busy, 0);
    endtask

    task automatic do_abort(input int frm, input int nbits, input int rlen);
        bit hit;
        reset = 1'b1;
        corrupt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear_capture();
        hit = 1'b0;
        for (int k = 0; k < 6000 && !hit; k++) begin
            @(negedge clock);
            if (cap_q.size() == frm && !csN && bits_in == nbits) hit = 1'b1;
        end
        check($sformatf("abort_point_f%0d_b%0d", frm, nbits), hit, 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_csn", csN, 1);
        check("abort_rstn", codecRstN, 0);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 1);
        check("abort_done", done, 0);
        repeat (rlen - 1) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_codecRstN", codecRstN, 0);
        check("rst_csN", csN, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        do_run(1'b0);
        do_abort(4, 6, 1);
        do_run(1'b0);
        do_abort(int'($urandom_range(0, 6)), int'($urandom_range(1, 15)), int'($urandom_range(1, 3)));
        do_run(1'b0);
`ifdef CODEC_READBACK_EN
        do_abort(1, 3, 1);
        do_run(1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
